timeclock_set_controller: RTL and testbench
===========================================

Name: timeclock_set_controller

Overview:
- Sequences manual time-setting of the time-clock counter from three debounced button pulses (mode, up, down).
- In RUN it enables counting. In SET it freezes the counter and edits shadow hour/min/sec fields.
- On commit it issues a one-cycle parallel load; on abort or timeout it discards the edits.
- Drives the edit-field select and blink phase used by the FND digit/mux path to flash the field under edit.

Parameters:
- BLINK_TICKS, 50, i_tick_10ms pulses per blink half-period (500 ms).
- TIMEOUT_TICKS, 1000, idle i_tick_10ms pulses before a SET-mode abort (10 s).
- HOUR_MAX, 23, largest hour value.
- MINSEC_MAX, 59, largest minute/second value.

Ports:
- i_clk  in  1  system clock; the only clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_tick_10ms  in  1  one-i_clk-cycle pulse every 10 ms.
- i_btn_mode  in  1  one-cycle pulse; advances edit field.
- i_btn_up  in  1  one-cycle pulse; increments the field under edit.
- i_btn_down  in  1  one-cycle pulse; decrements the field under edit.
- i_hour  in  6  live counter hour.
- i_min  in  6  live counter minute.
- i_sec  in  6  live counter second.
- o_run_en  out  1  counter count enable.
- o_load  out  1  one-cycle parallel-load strobe to the counter.
- o_set_hour  out  6  shadow hour; valid whenever o_load=1.
- o_set_min  out  6  shadow minute.
- o_set_sec  out  6  shadow second.
- o_edit_field  out  2  field under edit: 0=none, 1=hour, 2=min, 3=sec.
- o_blink  out  1  1 = show the edited field, 0 = blank it.

Behaviour:
- Reset (i_reset=0, asynchronous): state RUN; o_run_en=1; o_load=0; shadows=0; o_edit_field=0; o_blink=1; blink and idle counters=0.
- All outputs are registered. A state change is visible the cycle after the input pulse.

State machine:
- States: RUN, SET_HOUR, SET_MIN, SET_SEC, COMMIT.
- RUN: o_run_en=1. Up/down pulses are ignored. A mode pulse captures i_hour/i_min/i_sec into the shadows in the same edge and moves to SET_HOUR.
- SET_HOUR, SET_MIN and SET_SEC: o_run_en=0.
  - Mode pulse: SET_HOUR→SET_MIN→SET_SEC→COMMIT.
  - Up/down pulse edits only the selected shadow field.
- COMMIT: lasts exactly one cycle with o_load=1 and o_run_en=0; then RUN.
  - Latency from the third SET-mode pulse (the one leaving SET_SEC) to o_load high: 1 cycle.
  - Shadows hold their values after commit.

Arithmetic and wrap (6-bit unsigned):
- Hour: HOUR_MAX+1 → 0; 0−1 → HOUR_MAX.
- Min/sec: MINSEC_MAX+1 → 0; 0−1 → MINSEC_MAX.
- If a captured value exceeds its max (corrupt counter), the next up or down pulse sets the field to 0.

Simultaneous events:
- Mode together with up/down: mode wins; the edit is dropped.
- Up and down in the same cycle: both ignored, and the idle counter is still cleared.

Blink and idle counters:
- Blink counter advances on i_tick_10ms in SET states only.
- o_blink toggles when the blink counter reaches BLINK_TICKS−1; the counter then returns to 0.
- Any button pulse in SET forces o_blink=1 and clears the blink counter, so the field stays solid while being edited.
- In RUN and COMMIT, o_blink=1 and o_edit_field=0.

Timeout:
- Idle counter increments on i_tick_10ms in SET states and clears on any button pulse.
- At TIMEOUT_TICKS: go to RUN with no o_load; shadows are discarded.
- Idle and blink counters clear on entering RUN.

Mid-operation reset: returns to RUN with no load strobe and o_run_en=1 immediately (asynchronous assertion).

Test Plan:
- Release reset with i_hour/i_min/i_sec=12/34/56 → o_run_en=1, o_load=0, o_edit_field=0, o_blink=1.
- Mode pulse with live 12/34/56; up×3 in hour; mode; down×1 in min; mode; mode → single-cycle o_load=1 with o_set_*=15/33/56, then o_run_en=1 the next cycle.
- Hour=23 then up → 0; min=0 then down → 59; sec=59 then up → 0; up and down in the same cycle → no change.
- Enter SET_HOUR, no buttons for 1000 ticks → RUN, o_load never asserted, o_run_en=1.
- In SET_MIN with no buttons → o_blink toggles every 50 ticks; an up pulse forces o_blink=1 and the next toggle comes 50 ticks later.
- Assert i_reset=0 during SET_SEC, asynchronously to i_clk → o_run_en=1 and o_edit_field=0 before the next clock edge; no o_load.

Source files
------------

// File: rtl/timeclock_set_controller.sv
//------------------------------------------------------------------------------
// Module      : timeclock_set_controller
// Description : RUN/SET sequencer for manual time-setting of the time-clock
//               counter, with shadow fields, commit load strobe and blink phase.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module timeclock_set_controller #(
    parameter int BLINK_TICKS   = 50,
    parameter int TIMEOUT_TICKS = 1000,
    parameter int HOUR_MAX      = 23,
    parameter int MINSEC_MAX    = 59
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tick_10ms,
    input  logic       i_btn_mode,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    input  logic [5:0] i_hour,
    input  logic [5:0] i_min,
    input  logic [5:0] i_sec,
    output logic       o_run_en,
    output logic       o_load,
    output logic [5:0] o_set_hour,
    output logic [5:0] o_set_min,
    output logic [5:0] o_set_sec,
    output logic [1:0] o_edit_field,
    output logic       o_blink
);

    localparam logic [2:0] c_ST_RUN      = 3'd0;
    localparam logic [2:0] c_ST_SET_HOUR = 3'd1;
    localparam logic [2:0] c_ST_SET_MIN  = 3'd2;
    localparam logic [2:0] c_ST_SET_SEC  = 3'd3;
    localparam logic [2:0] c_ST_COMMIT   = 3'd4;

    localparam int c_BLINK_W = $clog2(BLINK_TICKS + 1);
    localparam int c_IDLE_W  = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_TICKS - 1);
    localparam logic [c_IDLE_W-1:0]  c_IDLE_LAST  = c_IDLE_W'(TIMEOUT_TICKS - 1);
    localparam logic [5:0]           c_HOUR_MAX   = 6'(HOUR_MAX);
    localparam logic [5:0]           c_MINSEC_MAX = 6'(MINSEC_MAX);

    logic [2:0]           r_state;
    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic [c_IDLE_W-1:0]  r_idle_cnt;
    logic                 r_run_en;
    logic                 r_load;
    logic [5:0]           r_set_hour;
    logic [5:0]           r_set_min;
    logic [5:0]           r_set_sec;
    logic [1:0]           r_edit_field;
    logic                 r_blink;

    logic       w_any_btn;
    logic       w_edit;
    logic [5:0] w_hour_next;
    logic [5:0] w_min_next;
    logic [5:0] w_sec_next;

    // Out-of-range values (corrupt live capture) snap to zero on any edit.
    function automatic logic [5:0] f_inc(input logic [5:0] val, input logic [5:0] max);
        if (val >= max) return 6'd0;
        return val + 6'd1;
    endfunction

    function automatic logic [5:0] f_dec(input logic [5:0] val, input logic [5:0] max);
        if (val > max)   return 6'd0;
        if (val == 6'd0) return max;
        return val - 6'd1;
    endfunction

    assign w_any_btn   = i_btn_mode | i_btn_up | i_btn_down;
    assign w_edit      = i_btn_up ^ i_btn_down;
    assign w_hour_next = i_btn_up ? f_inc(r_set_hour, c_HOUR_MAX)   : f_dec(r_set_hour, c_HOUR_MAX);
    assign w_min_next  = i_btn_up ? f_inc(r_set_min,  c_MINSEC_MAX) : f_dec(r_set_min,  c_MINSEC_MAX);
    assign w_sec_next  = i_btn_up ? f_inc(r_set_sec,  c_MINSEC_MAX) : f_dec(r_set_sec,  c_MINSEC_MAX);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= c_ST_RUN;
            r_blink_cnt  <= '0;
            r_idle_cnt   <= '0;
            r_run_en     <= 1'b1;
            r_load       <= 1'b0;
            r_set_hour   <= 6'd0;
            r_set_min    <= 6'd0;
            r_set_sec    <= 6'd0;
            r_edit_field <= 2'd0;
            r_blink      <= 1'b1;
        end else begin
            r_load <= 1'b0;
            case (r_state)
                c_ST_RUN: begin
                    r_run_en     <= 1'b1;
                    r_edit_field <= 2'd0;
                    r_blink      <= 1'b1;
                    r_blink_cnt  <= '0;
                    r_idle_cnt   <= '0;
                    if (i_btn_mode) begin
                        r_set_hour   <= i_hour;
                        r_set_min    <= i_min;
                        r_set_sec    <= i_sec;
                        r_state      <= c_ST_SET_HOUR;
                        r_run_en     <= 1'b0;
                        r_edit_field <= 2'd1;
                    end
                end

                c_ST_SET_HOUR, c_ST_SET_MIN, c_ST_SET_SEC: begin
                    r_run_en <= 1'b0;
                    // Any press, even a cancelled up+down, keeps the field solid and resets idle.
                    if (w_any_btn) begin
                        r_blink     <= 1'b1;
                        r_blink_cnt <= '0;
                        r_idle_cnt  <= '0;
                    end
                    if (i_btn_mode) begin
                        case (r_state)
                            c_ST_SET_HOUR: begin
                                r_state      <= c_ST_SET_MIN;
                                r_edit_field <= 2'd2;
                            end
                            c_ST_SET_MIN: begin
                                r_state      <= c_ST_SET_SEC;
                                r_edit_field <= 2'd3;
                            end
                            default: begin
                                r_state      <= c_ST_COMMIT;
                                r_edit_field <= 2'd0;
                                r_load       <= 1'b1;
                            end
                        endcase
                    end else if (w_edit) begin
                        case (r_state)
                            c_ST_SET_HOUR: r_set_hour <= w_hour_next;
                            c_ST_SET_MIN:  r_set_min  <= w_min_next;
                            default:       r_set_sec  <= w_sec_next;
                        endcase
                    end else if (!w_any_btn && i_tick_10ms) begin
                        if (r_idle_cnt == c_IDLE_LAST) begin
                            r_state      <= c_ST_RUN;
                            r_run_en     <= 1'b1;
                            r_edit_field <= 2'd0;
                            r_blink      <= 1'b1;
                            r_blink_cnt  <= '0;
                            r_idle_cnt   <= '0;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + 1'b1;
                            if (r_blink_cnt == c_BLINK_LAST) begin
                                r_blink     <= ~r_blink;
                                r_blink_cnt <= '0;
                            end else begin
                                r_blink_cnt <= r_blink_cnt + 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    r_state      <= c_ST_RUN;
                    r_run_en     <= 1'b1;
                    r_edit_field <= 2'd0;
                    r_blink      <= 1'b1;
                    r_blink_cnt  <= '0;
                    r_idle_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_run_en     = r_run_en;
    assign o_load       = r_load;
    assign o_set_hour   = r_set_hour;
    assign o_set_min    = r_set_min;
    assign o_set_sec    = r_set_sec;
    assign o_edit_field = r_edit_field;
    assign o_blink      = r_blink;

endmodule

`default_nettype wire

// File: tb/tb_timeclock_set_controller.sv
//------------------------------------------------------------------------------
// Module      : tb_timeclock_set_controller
// Description : Vector-table and directed-sequence bench for the set controller.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_timeclock_set_controller;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_tick_10ms = 1'b0;
    logic       i_btn_mode = 1'b0;
    logic       i_btn_up = 1'b0;
    logic       i_btn_down = 1'b0;
    logic [5:0] i_hour = 6'd0;
    logic [5:0] i_min = 6'd0;
    logic [5:0] i_sec = 6'd0;
    logic       o_run_en;
    logic       o_load;
    logic [5:0] o_set_hour;
    logic [5:0] o_set_min;
    logic [5:0] o_set_sec;
    logic [1:0] o_edit_field;
    logic       o_blink;

    int n_cmp = 0;
    int n_err = 0;

    timeclock_set_controller #(
        .BLINK_TICKS  (50),
        .TIMEOUT_TICKS(1000),
        .HOUR_MAX     (23),
        .MINSEC_MAX   (59)
    ) u_dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_tick_10ms (i_tick_10ms),
        .i_btn_mode  (i_btn_mode),
        .i_btn_up    (i_btn_up),
        .i_btn_down  (i_btn_down),
        .i_hour      (i_hour),
        .i_min       (i_min),
        .i_sec       (i_sec),
        .o_run_en    (o_run_en),
        .o_load      (o_load),
        .o_set_hour  (o_set_hour),
        .o_set_min   (o_set_min),
        .o_set_sec   (o_set_sec),
        .o_edit_field(o_edit_field),
        .o_blink     (o_blink)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        m;
        logic        u;
        logic        d;
        logic [5:0]  lh;
        logic [5:0]  lm;
        logic [5:0]  ls;
        logic [22:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Expected word: {run_en, load, edit_field, blink, hour, min, sec}
    function automatic vec_t mk(input logic m, u, d, input int lh, lm, ls,
                                input logic run, ld, input int ef, input logic bl,
                                input int h, mi, s);
        vec_t v;
        v.m = m; v.u = u; v.d = d;
        v.lh = 6'(lh); v.lm = 6'(lm); v.ls = 6'(ls);
        v.exp = {run, ld, 2'(ef), bl, 6'(h), 6'(mi), 6'(s)};
        return v;
    endfunction

    function automatic logic [22:0] outs();
        return {o_run_en, o_load, o_edit_field, o_blink, o_set_hour, o_set_min, o_set_sec};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; holds inputs for one rising edge, returns at the next negedge.
    task automatic step(input logic m, u, d, t);
        i_btn_mode = m; i_btn_up = u; i_btn_down = d; i_tick_10ms = t;
        @(negedge i_clk);
        i_btn_mode = 1'b0; i_btn_up = 1'b0; i_btn_down = 1'b0; i_tick_10ms = 1'b0;
    endtask

    initial begin
        int load_seen;

        // 12/34/56: edit hour up x3, min down, mode+up and up+down dropped, commit.
        vecs.push_back(mk(0,0,0, 12,34,56, 1,0,0,1,  0, 0, 0));
        vecs.push_back(mk(1,0,0, 12,34,56, 0,0,1,1, 12,34,56));
        vecs.push_back(mk(0,1,0, 12,34,56, 0,0,1,1, 13,34,56));
        vecs.push_back(mk(0,1,0, 12,34,56, 0,0,1,1, 14,34,56));
        vecs.push_back(mk(0,1,0, 12,34,56, 0,0,1,1, 15,34,56));
        vecs.push_back(mk(1,0,0, 12,34,56, 0,0,2,1, 15,34,56));
        vecs.push_back(mk(0,0,1, 12,34,56, 0,0,2,1, 15,33,56));
        vecs.push_back(mk(1,1,0, 12,34,56, 0,0,3,1, 15,33,56));
        vecs.push_back(mk(0,1,1, 12,34,56, 0,0,3,1, 15,33,56));
        vecs.push_back(mk(1,0,0, 12,34,56, 0,1,0,1, 15,33,56));
        vecs.push_back(mk(0,0,0, 12,34,56, 1,0,0,1, 15,33,56));
        vecs.push_back(mk(0,1,0, 12,34,56, 1,0,0,1, 15,33,56));
        // Wrap boundaries from 23/00/59.
        vecs.push_back(mk(1,0,0, 23,0,59, 0,0,1,1, 23, 0,59));
        vecs.push_back(mk(0,1,0, 23,0,59, 0,0,1,1,  0, 0,59));
        vecs.push_back(mk(0,0,1, 23,0,59, 0,0,1,1, 23, 0,59));
        vecs.push_back(mk(1,0,0, 23,0,59, 0,0,2,1, 23, 0,59));
        vecs.push_back(mk(0,0,1, 23,0,59, 0,0,2,1, 23,59,59));
        vecs.push_back(mk(0,1,0, 23,0,59, 0,0,2,1, 23, 0,59));
        vecs.push_back(mk(1,0,0, 23,0,59, 0,0,3,1, 23, 0,59));
        vecs.push_back(mk(0,1,0, 23,0,59, 0,0,3,1, 23, 0, 0));
        vecs.push_back(mk(0,0,1, 23,0,59, 0,0,3,1, 23, 0,59));
        vecs.push_back(mk(1,0,0, 23,0,59, 0,1,0,1, 23, 0,59));
        vecs.push_back(mk(0,0,0, 23,0,59, 1,0,0,1, 23, 0,59));
        // Corrupt live values snap to zero on first edit.
        vecs.push_back(mk(1,0,0, 63,60,60, 0,0,1,1, 63,60,60));
        vecs.push_back(mk(0,0,1, 63,60,60, 0,0,1,1,  0,60,60));
        vecs.push_back(mk(1,0,0, 63,60,60, 0,0,2,1,  0,60,60));
        vecs.push_back(mk(0,1,0, 63,60,60, 0,0,2,1,  0, 0,60));
        vecs.push_back(mk(1,0,0, 63,60,60, 0,0,3,1,  0, 0,60));
        vecs.push_back(mk(0,0,1, 63,60,60, 0,0,3,1,  0, 0, 0));
        vecs.push_back(mk(1,0,0, 63,60,60, 0,1,0,1,  0, 0, 0));
        vecs.push_back(mk(0,0,0, 63,60,60, 1,0,0,1,  0, 0, 0));

        i_hour = 6'd12; i_min = 6'd34; i_sec = 6'd56;
        repeat (3) @(negedge i_clk);
        chk("reset_state", 32'(outs()), 32'({1'b1, 1'b0, 2'd0, 1'b1, 18'd0}));
        i_reset = 1'b1;
        @(negedge i_clk);

        foreach (vecs[k]) begin
            i_hour = vecs[k].lh; i_min = vecs[k].lm; i_sec = vecs[k].ls;
            step(vecs[k].m, vecs[k].u, vecs[k].d, 1'b0);
            chk($sformatf("vec%0d", k), 32'(outs()), 32'(vecs[k].exp));
        end

        // Idle timeout from SET_HOUR.
        i_hour = 6'd1; i_min = 6'd2; i_sec = 6'd3;
        step(1, 0, 0, 0);
        chk("to_enter_edit", 32'(o_edit_field), 32'd1);
        load_seen = 0;
        for (int i = 0; i < 999; i++) begin
            step(0, 0, 0, 1);
            if (o_load) load_seen++;
        end
        chk("to_999_still_set", 32'({o_run_en, o_edit_field}), 32'({1'b0, 2'd1}));
        step(0, 0, 0, 1);
        if (o_load) load_seen++;
        chk("to_1000_run", 32'({o_run_en, o_edit_field, o_blink}), 32'({1'b1, 2'd0, 1'b1}));
        chk("to_no_load", 32'(load_seen), 32'd0);
        step(0, 0, 0, 0);
        chk("to_after_no_load", 32'({o_run_en, o_load}), 32'({1'b1, 1'b0}));

        // Blink phase in SET_MIN.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("bl_edit_min", 32'(o_edit_field), 32'd2);
        repeat (49) step(0, 0, 0, 1);
        chk("bl_49_solid", 32'(o_blink), 32'd1);
        step(0, 0, 0, 1);
        chk("bl_50_off", 32'(o_blink), 32'd0);
        repeat (49) step(0, 0, 0, 1);
        chk("bl_99_off", 32'(o_blink), 32'd0);
        step(0, 0, 0, 1);
        chk("bl_100_on", 32'(o_blink), 32'd1);
        repeat (50) step(0, 0, 0, 1);
        chk("bl_150_off", 32'(o_blink), 32'd0);
        repeat (20) step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        chk("bl_up_forces_on", 32'(o_blink), 32'd1);
        repeat (49) step(0, 0, 0, 1);
        chk("bl_up_49_on", 32'(o_blink), 32'd1);
        step(0, 0, 0, 1);
        chk("bl_up_50_off", 32'(o_blink), 32'd0);

        // Asynchronous reset mid-cycle while in SET_SEC.
        step(1, 0, 0, 0);
        chk("ar_edit_sec", 32'({o_run_en, o_edit_field}), 32'({1'b0, 2'd3}));
        @(posedge i_clk);
        #2 i_reset = 1'b0;
        #1;
        chk("ar_immediate", 32'({o_run_en, o_load, o_edit_field}), 32'({1'b1, 1'b0, 2'd0}));
        @(negedge i_clk);
        i_reset = 1'b1;
        step(0, 0, 0, 0);
        chk("ar_after_release", 32'({o_run_en, o_load, o_edit_field, o_blink}),
            32'({1'b1, 1'b0, 2'd0, 1'b1}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
